// File: rtl/fpu_dit_monitor_if.sv
// Bus between the dual-FPU miter and its timing monitor: the shared request strobe,
// both copies' response strobes, and the monitor's registered status.
interface fpu_dit_monitor_if #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Handshake: every *_valid is a single-cycle qualifier sampled on the rising edge.
  // There is no ready; the monitor accepts unconditionally and never stalls an FPU.
  logic            clear;
  logic            req_valid;
  logic            resp_valid_a;
  logic            resp_valid_b;
  logic            fflags_valid_a;
  logic            fflags_valid_b;

  logic [CW-1:0]   outstanding;
  logic            lat_valid_a;
  logic            lat_valid_b;
  logic [TS_W-1:0] lat_a;
  logic [TS_W-1:0] lat_b;
  logic            diverged;
  logic [1:0]      div_cause;
  logic [TS_W-1:0] div_stamp;
  logic            overflow;
  logic            underflow;
  logic            state_dbg;

  modport slave (
    input  clear, req_valid, resp_valid_a, resp_valid_b, fflags_valid_a, fflags_valid_b,
    output outstanding, lat_valid_a, lat_valid_b, lat_a, lat_b,
           diverged, div_cause, div_stamp, overflow, underflow, state_dbg
  );

  modport master (
    output clear, req_valid, resp_valid_a, resp_valid_b, fflags_valid_a, fflags_valid_b,
    input  outstanding, lat_valid_a, lat_valid_b, lat_a, lat_b,
           diverged, div_cause, div_stamp, overflow, underflow, state_dbg
  );
endinterface

// File: rtl/fpu_dit_monitor.sv
// Timing observer for the dual-FPU miter: stamps requests, measures per-copy latency,
// and latches the first cycle where the two copies' response timing diverges.
module fpu_dit_monitor #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  fpu_dit_monitor_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {RUN = 1'b0, DIVERGED = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [TS_W-1:0] now_q;
  logic [TS_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]   wr_q, rd_a_q, rd_b_q;
  logic [PW-1:0]   wr_d, rd_a_d, rd_b_d;
  logic [PW-1:0]   occ_a, occ_b, occ_max, occ_a_d, occ_b_d, occ_next;
  logic            pend_a, pend_b, full;
  logic            push, pop_a, pop_b;
  logic [TS_W-1:0] lat_a_c, lat_b_c;
  logic [1:0]      cause_c;
  logic            div_latch;

  logic [PW-1:0]   outstanding_q;
  logic            lat_valid_a_q, lat_valid_b_q;
  logic [TS_W-1:0] lat_a_q, lat_b_q;
  logic            diverged_q;
  logic [1:0]      div_cause_q;
  logic [TS_W-1:0] div_stamp_q;
  logic            overflow_q, underflow_q;

  // Pending/full status comes from start-of-cycle pointers, so a same-cycle pop never
  // makes room for a push and a same-cycle push never satisfies a pop.
  always_comb begin
    occ_a   = wr_q - rd_a_q;
    occ_b   = wr_q - rd_b_q;
    occ_max = (occ_a > occ_b) ? occ_a : occ_b;
    full    = (occ_max == PW'(DEPTH));
    pend_a  = (occ_a != '0);
    pend_b  = (occ_b != '0);
    push    = bus.req_valid    & ~full;
    pop_a   = bus.resp_valid_a & pend_a;
    pop_b   = bus.resp_valid_b & pend_b;
    lat_a_c = now_q - mem_q[rd_a_q[AW-1:0]];
    lat_b_c = now_q - mem_q[rd_b_q[AW-1:0]];
    wr_d    = push  ? wr_q   + PW'(1) : wr_q;
    rd_a_d  = pop_a ? rd_a_q + PW'(1) : rd_a_q;
    rd_b_d  = pop_b ? rd_b_q + PW'(1) : rd_b_q;
    occ_a_d = wr_d - rd_a_d;
    occ_b_d = wr_d - rd_b_d;
    occ_next = (occ_a_d > occ_b_d) ? occ_a_d : occ_b_d;
  end

  // Divergence cause, highest priority first: valid mismatch, fflags mismatch, latency.
  always_comb begin
    cause_c = 2'b00;
    if (bus.resp_valid_a != bus.resp_valid_b) begin
      cause_c = 2'b01;
    end else if (bus.resp_valid_a && bus.resp_valid_b &&
                 (bus.fflags_valid_a != bus.fflags_valid_b)) begin
      cause_c = 2'b11;
    end else if (pop_a && pop_b && (lat_a_c != lat_b_c)) begin
      cause_c = 2'b10;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_latch = 1'b0;
    if (bus.clear) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (cause_c != 2'b00) begin
            state_d   = DIVERGED;
            div_latch = 1'b1;
          end
        end
        DIVERGED: state_d = DIVERGED;
        default:  state_d = RUN;
      endcase
    end
  end

  // Storage is not reset: an entry is only read after a push has written it.
  always_ff @(posedge clock) begin
    if (push && !bus.clear) begin
      mem_q[wr_q[AW-1:0]] <= now_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      now_q         <= '0;
      wr_q          <= '0;
      rd_a_q        <= '0;
      rd_b_q        <= '0;
      outstanding_q <= '0;
      lat_valid_a_q <= 1'b0;
      lat_valid_b_q <= 1'b0;
      lat_a_q       <= '0;
      lat_b_q       <= '0;
      diverged_q    <= 1'b0;
      div_cause_q   <= 2'b00;
      div_stamp_q   <= '0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      now_q         <= now_q + TS_W'(1);
      state_q       <= state_d;
      lat_valid_a_q <= 1'b0;
      lat_valid_b_q <= 1'b0;
      if (bus.clear) begin
        wr_q          <= '0;
        rd_a_q        <= '0;
        rd_b_q        <= '0;
        outstanding_q <= '0;
        lat_a_q       <= '0;
        lat_b_q       <= '0;
        diverged_q    <= 1'b0;
        div_cause_q   <= 2'b00;
        div_stamp_q   <= '0;
        overflow_q    <= 1'b0;
        underflow_q   <= 1'b0;
      end else begin
        wr_q          <= wr_d;
        rd_a_q        <= rd_a_d;
        rd_b_q        <= rd_b_d;
        outstanding_q <= occ_next;
        if (bus.req_valid && full) overflow_q <= 1'b1;
        if ((bus.resp_valid_a && !pend_a) || (bus.resp_valid_b && !pend_b)) begin
          underflow_q <= 1'b1;
        end
        if (pop_a) begin
          lat_a_q       <= lat_a_c;
          lat_valid_a_q <= 1'b1;
        end
        if (pop_b) begin
          lat_b_q       <= lat_b_c;
          lat_valid_b_q <= 1'b1;
        end
        if (div_latch) begin
          diverged_q  <= 1'b1;
          div_cause_q <= cause_c;
          div_stamp_q <= now_q;
        end
      end
    end
  end

  assign bus.outstanding = outstanding_q;
  assign bus.lat_valid_a = lat_valid_a_q;
  assign bus.lat_valid_b = lat_valid_b_q;
  assign bus.lat_a       = lat_a_q;
  assign bus.lat_b       = lat_b_q;
  assign bus.diverged    = diverged_q;
  assign bus.div_cause   = div_cause_q;
  assign bus.div_stamp   = div_stamp_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
  assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_fpu_dit_monitor.sv
// Directed bench for fpu_dit_monitor: a DEPTH=8/TS_W=16 instance for the main
// scenarios and a DEPTH=4/TS_W=4 instance for timestamp wrap.
module tb_fpu_dit_monitor;
  logic clock;
  logic reset;
  int   n_pass;
  int   n_total;
  int   n_fail;
  int   tb_now;

  fpu_dit_monitor_if #(.DEPTH(8), .TS_W(16)) bus1 ();
  fpu_dit_monitor_if #(.DEPTH(4), .TS_W(4))  bus2 ();

  fpu_dit_monitor #(.DEPTH(8), .TS_W(16)) dut1 (.clock(clock), .reset(reset), .bus(bus1));
  fpu_dit_monitor #(.DEPTH(4), .TS_W(4))  dut2 (.clock(clock), .reset(reset), .bus(bus2));

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs already set are sampled at this edge; outputs read #1 later.
  task automatic cyc();
    @(posedge clock);
    #1;
    tb_now++;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic drv(input logic rq, input logic ra, input logic rb,
                     input logic fa, input logic fb);
    bus1.req_valid      = rq;
    bus1.resp_valid_a   = ra;
    bus1.resp_valid_b   = rb;
    bus1.fflags_valid_a = fa;
    bus1.fflags_valid_b = fb;
    cyc();
    bus1.req_valid      = 1'b0;
    bus1.resp_valid_a   = 1'b0;
    bus1.resp_valid_b   = 1'b0;
    bus1.fflags_valid_a = 1'b0;
    bus1.fflags_valid_b = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_outstanding"}, 32'(bus1.outstanding), 32'd0);
    chk({tag, "_lat_valid_a"}, 32'(bus1.lat_valid_a), 32'd0);
    chk({tag, "_lat_valid_b"}, 32'(bus1.lat_valid_b), 32'd0);
    chk({tag, "_lat_a"},       32'(bus1.lat_a),       32'd0);
    chk({tag, "_lat_b"},       32'(bus1.lat_b),       32'd0);
    chk({tag, "_diverged"},    32'(bus1.diverged),    32'd0);
    chk({tag, "_div_cause"},   32'(bus1.div_cause),   32'd0);
    chk({tag, "_div_stamp"},   32'(bus1.div_stamp),   32'd0);
    chk({tag, "_overflow"},    32'(bus1.overflow),    32'd0);
    chk({tag, "_underflow"},   32'(bus1.underflow),   32'd0);
    chk({tag, "_state"},       32'(bus1.state_dbg),   32'd0);
  endtask

  // Reset asserted for one edge, released 1 time unit after it: the next edge samples now=0.
  task automatic do_reset();
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset  = 1'b1;
    tb_now = 0;
  endtask

  initial begin
    n_pass = 0; n_total = 0; n_fail = 0; tb_now = 0;
    reset = 1'b0;
    bus1.clear = 1'b0; bus1.req_valid = 1'b0; bus1.resp_valid_a = 1'b0; bus1.resp_valid_b = 1'b0;
    bus1.fflags_valid_a = 1'b0; bus1.fflags_valid_b = 1'b0;
    bus2.clear = 1'b0; bus2.req_valid = 1'b0; bus2.resp_valid_a = 1'b0; bus2.resp_valid_b = 1'b0;
    bus2.fflags_valid_a = 1'b0; bus2.fflags_valid_b = 1'b0;

    // Reset values
    #2;
    chk_zero("rst");
    chk("rst_dut2_outstanding", 32'(bus2.outstanding), 32'd0);
    do_reset();

    // Matching pair: req at now=3, both respond at now=7
    idle(3);
    drv(1, 0, 0, 0, 0);
    chk("s1_outstanding_1", 32'(bus1.outstanding), 32'd1);
    idle(3);
    drv(0, 1, 1, 1, 1);
    chk("s1_lat_valid_a", 32'(bus1.lat_valid_a), 32'd1);
    chk("s1_lat_valid_b", 32'(bus1.lat_valid_b), 32'd1);
    chk("s1_lat_a",       32'(bus1.lat_a),       32'd4);
    chk("s1_lat_b",       32'(bus1.lat_b),       32'd4);
    chk("s1_diverged",    32'(bus1.diverged),    32'd0);
    chk("s1_outstanding", 32'(bus1.outstanding), 32'd0);
    idle(1);
    chk("s1_pulse_end",   32'(bus1.lat_valid_a), 32'd0);
    chk("s1_lat_a_hold",  32'(bus1.lat_a),       32'd4);

    // Valid mismatch: req at now=2, A at now=5, B at now=6
    do_reset();
    idle(2);
    drv(1, 0, 0, 0, 0);
    idle(2);
    drv(0, 1, 0, 0, 0);
    chk("s2_diverged",    32'(bus1.diverged),    32'd1);
    chk("s2_cause",       32'(bus1.div_cause),   32'd1);
    chk("s2_stamp",       32'(bus1.div_stamp),   32'd5);
    chk("s2_lat_a",       32'(bus1.lat_a),       32'd3);
    chk("s2_outstanding", 32'(bus1.outstanding), 32'd1);
    chk("s2_state",       32'(bus1.state_dbg),   32'd1);
    drv(0, 0, 1, 0, 0);
    chk("s2_lat_valid_b", 32'(bus1.lat_valid_b), 32'd1);
    chk("s2_lat_valid_a", 32'(bus1.lat_valid_a), 32'd0);
    chk("s2_lat_b",       32'(bus1.lat_b),       32'd4);
    chk("s2_outstanding0",32'(bus1.outstanding), 32'd0);
    chk("s2_cause_keep",  32'(bus1.div_cause),   32'd1);
    drv(1, 0, 0, 0, 0);
    drv(0, 1, 1, 0, 0);
    chk("s2_pair_lat_a",  32'(bus1.lat_a),       32'd1);
    chk("s2_pair_lat_b",  32'(bus1.lat_b),       32'd1);
    chk("s2_still_div",   32'(bus1.diverged),    32'd1);
    chk("s2_stamp_keep",  32'(bus1.div_stamp),   32'd5);
    chk("s2_state_keep",  32'(bus1.state_dbg),   32'd1);

    // Clear with a simultaneous req (ignored), then fflags mismatch at now=11
    bus1.clear = 1'b1;
    drv(1, 0, 0, 0, 0);
    bus1.clear = 1'b0;
    chk_zero("clr1");
    drv(1, 0, 0, 0, 0);
    drv(0, 1, 1, 1, 0);
    chk("s3_diverged", 32'(bus1.diverged),  32'd1);
    chk("s3_cause",    32'(bus1.div_cause), 32'd3);
    chk("s3_stamp",    32'(bus1.div_stamp), 32'd11);
    chk("s3_lat_a",    32'(bus1.lat_a),     32'd1);
    bus1.clear = 1'b1;
    cyc();
    bus1.clear = 1'b0;
    chk_zero("clr2");

    // Fill to 8, 9th req overflows while the first pair pops; drain with lat=8
    for (int i = 0; i < 8; i++) drv(1, 0, 0, 0, 0);
    chk("s4_outstanding_8", 32'(bus1.outstanding), 32'd8);
    chk("s4_no_overflow",   32'(bus1.overflow),    32'd0);
    drv(1, 1, 1, 0, 0);
    chk("s4_overflow",      32'(bus1.overflow),    32'd1);
    chk("s4_outstanding_7", 32'(bus1.outstanding), 32'd7);
    chk("s4_lat_a_first",   32'(bus1.lat_a),       32'd8);
    chk("s4_lat_b_first",   32'(bus1.lat_b),       32'd8);
    for (int i = 0; i < 7; i++) begin
      drv(0, 1, 1, 0, 0);
      chk("s4_lat_a", 32'(bus1.lat_a), 32'd8);
      chk("s4_lat_b", 32'(bus1.lat_b), 32'd8);
    end
    chk("s4_drained",       32'(bus1.outstanding), 32'd0);
    chk("s4_diverged",      32'(bus1.diverged),    32'd0);
    chk("s4_overflow_keep", 32'(bus1.overflow),    32'd1);

    // Underflow on copy A alone
    drv(0, 1, 0, 0, 0);
    chk("s5_underflow",   32'(bus1.underflow),   32'd1);
    chk("s5_no_pulse",    32'(bus1.lat_valid_a), 32'd0);
    chk("s5_lat_a_hold",  32'(bus1.lat_a),       32'd8);
    chk("s5_cause",       32'(bus1.div_cause),   32'd1);

    // Asynchronous reset in the middle of a request burst
    bus1.req_valid = 1'b1;
    cyc();
    cyc();
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk_zero("async_rst");
    bus1.req_valid = 1'b0;
    @(posedge clock);
    #1;
    reset  = 1'b1;
    tb_now = 0;
    drv(1, 0, 0, 0, 0);
    chk("s5_post_outstanding", 32'(bus1.outstanding), 32'd1);
    idle(1);
    drv(0, 1, 1, 0, 0);
    chk("s5_post_lat_a", 32'(bus1.lat_a), 32'd2);
    chk("s5_post_lat_b", 32'(bus1.lat_b), 32'd2);

    // Req and resp together on an empty FIFO: underflow, request still stored
    drv(1, 1, 1, 0, 0);
    chk("s6_underflow",   32'(bus1.underflow),   32'd1);
    chk("s6_outstanding", 32'(bus1.outstanding), 32'd1);
    chk("s6_no_pulse",    32'(bus1.lat_valid_a), 32'd0);
    chk("s6_diverged",    32'(bus1.diverged),    32'd0);

    // TS_W=4 wrap: req at now=14, response at now=2
    do_reset();
    idle(14);
    bus2.req_valid = 1'b1;
    cyc();
    bus2.req_valid = 1'b0;
    chk("s7_outstanding_1", 32'(bus2.outstanding), 32'd1);
    idle(3);
    bus2.resp_valid_a = 1'b1;
    bus2.resp_valid_b = 1'b1;
    cyc();
    bus2.resp_valid_a = 1'b0;
    bus2.resp_valid_b = 1'b0;
    chk("s7_lat_valid_a", 32'(bus2.lat_valid_a), 32'd1);
    chk("s7_lat_a",       32'(bus2.lat_a),       32'd4);
    chk("s7_lat_b",       32'(bus2.lat_b),       32'd4);
    chk("s7_diverged",    32'(bus2.diverged),    32'd0);
    chk("s7_outstanding", 32'(bus2.outstanding), 32'd0);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
